gray_serial_tx: RTL and testbench

- Downstream neighbour of the FIFO data-resolve stage.
- Accepts one resolved frame per handshake: a 128-bit Gray-coded payload (MSB-aligned, low bits zero), an 8-bit channel-select mask, and a valid bit count.
- Serialises the payload MSB-first, one bit per clock, onto every selected output lane.
- Reports completion or drop per frame; back-pressures the upstream stage while shifting.

---
 rtl/gray_tx_pkg.sv | 23 ++
 rtl/gray_tx_shreg.sv | 47 ++++
 rtl/gray_serial_tx.sv | 107 ++++++++++
 tb/tb_gray_serial_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_tx_pkg.sv
// Shared constants, FSM state type and bit-count clamp for the Gray-coded serial transmitter.
package gray_tx_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CH_NUM = 8;
  localparam int unsigned CNT_W  = 16;
  // Wide enough to hold the value DATA_W itself (a full frame).
  localparam int unsigned BL_W   = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Effective bit count: requests beyond the payload width send the whole payload.
  function automatic logic [BL_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
    if (cnt > CNT_W'(DATA_W)) begin
      return BL_W'(DATA_W);
    end
    return BL_W'(cnt);
  endfunction

endpackage

// File: rtl/gray_tx_shreg.sv
// Payload shift register and remaining-bit counter. Holds the bits still to be sent
// after the one currently on the wire, so next_bit_o is the bit for the following cycle.
module gray_tx_shreg
  import gray_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BL_W-1:0]   count_i,
  output logic              next_bit_o,
  output logic [BL_W-1:0]   bits_left_o,
  output logic              last_o
);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;

  // The payload MSB goes out directly on load, so the register starts pre-shifted.
  always_comb begin
    sreg_d      = sreg_q;
    bits_left_d = bits_left_q;
    if (load_i) begin
      sreg_d      = data_i << 1;
      bits_left_d = count_i;
    end else if (shift_i) begin
      sreg_d      = sreg_q << 1;
      bits_left_d = bits_left_q - BL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q      <= '0;
      bits_left_q <= '0;
    end else begin
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
    end
  end

  assign next_bit_o  = sreg_q[DATA_W-1];
  assign bits_left_o = bits_left_q;
  assign last_o      = (bits_left_q == BL_W'(1));

endmodule

// File: rtl/gray_serial_tx.sv
// Serialises one Gray-coded frame MSB-first onto the selected lanes, one bit per clock,
// with frame_done / frame_drop reporting and back-pressure while shifting.
module gray_serial_tx
  import gray_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_gray,
  input  logic [CH_NUM-1:0] vld_ch,
  input  logic [CNT_W-1:0]  data_count,
  output logic [CH_NUM-1:0] ser_data,
  output logic [CH_NUM-1:0] ser_vld,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_drop
);

  state_e            state_q, state_d;
  logic [CH_NUM-1:0] mask_q, mask_d;
  logic [CH_NUM-1:0] ser_data_d, ser_vld_d;
  logic              busy_d, in_ready_d, frame_done_d, frame_drop_d;
  logic              load, shift;
  logic [BL_W-1:0]   eff;
  logic              next_bit;
  logic [BL_W-1:0]   bits_left;
  logic              last;

  assign eff = clamp_count(data_count);

  gray_tx_shreg u_shreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .shift_i     (shift),
    .data_i      (data_gray),
    .count_i     (eff),
    .next_bit_o  (next_bit),
    .bits_left_o (bits_left),
    .last_o      (last)
  );

  // Outputs are computed for the cycle after the edge, so every port is a flop.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    load         = 1'b0;
    shift        = 1'b0;
    ser_data_d   = '0;
    ser_vld_d    = '0;
    frame_done_d = 1'b0;
    frame_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (eff == '0 || vld_ch == '0) begin
            frame_drop_d = 1'b1;
          end else begin
            load         = 1'b1;
            mask_d       = vld_ch;
            state_d      = SHIFT;
            ser_vld_d    = vld_ch;
            ser_data_d   = {CH_NUM{data_gray[DATA_W-1]}} & vld_ch;
            frame_done_d = (eff == BL_W'(1));
          end
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          state_d = IDLE;
        end else begin
          ser_vld_d    = mask_q;
          ser_data_d   = {CH_NUM{next_bit}} & mask_q;
          frame_done_d = (bits_left == BL_W'(2));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == SHIFT);
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      ser_data   <= '0;
      ser_vld    <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ser_data   <= ser_data_d;
      ser_vld    <= ser_vld_d;
      busy       <= busy_d;
      in_ready   <= in_ready_d;
      frame_done <= frame_done_d;
      frame_drop <= frame_drop_d;
    end
  end

endmodule

// File: tb/tb_gray_serial_tx.sv
// Scoreboard bench for gray_serial_tx: a frame-level model schedules expected per-cycle
// lane beats and drop pulses; a negedge monitor compares them against the DUT.
module tb_gray_serial_tx;

  localparam int unsigned DW = 128;
  localparam int unsigned CH = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_gray = '0;
  logic [CH-1:0] vld_ch = '0;
  logic [CW-1:0] data_count = '0;
  logic [CH-1:0] ser_data;
  logic [CH-1:0] ser_vld;
  logic          busy;
  logic          frame_done;
  logic          frame_drop;

  gray_serial_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_gray  (data_gray),
    .vld_ch     (vld_ch),
    .data_count (data_count),
    .ser_data   (ser_data),
    .ser_vld    (ser_vld),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] data;
    logic [CH-1:0] vld;
    logic          done;
  } beat_t;

  beat_t sb[$];
  int    drop_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: the first `eff` payload bits, MSB first, starting at `base`.
  function automatic void model(input logic [DW-1:0] d, input logic [CH-1:0] m,
                                input int n, input int base);
    int    eff;
    beat_t b;
    eff = (n > DW) ? DW : n;
    if (eff == 0 || m == '0) begin
      drop_q.push_back(base);
    end else begin
      for (int k = 0; k < eff; k++) begin
        b.cyc  = base + k;
        b.vld  = m;
        b.data = d[DW-1-k] ? m : '0;
        b.done = (k == eff - 1);
        sb.push_back(b);
      end
    end
  endfunction

  // Called at a negedge; offers a frame and holds it until the DUT is ready.
  task automatic send(input logic [DW-1:0] d, input logic [CH-1:0] m,
                      input logic [CW-1:0] n, output int base);
    int guard;
    guard      = 0;
    base       = -1;
    data_gray  = d;
    vld_ch     = m;
    data_count = n;
    in_valid   = 1'b1;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles (cycle %0d)", guard, cyc);
    end else begin
      base = cyc + 1;
      model(d, m, int'(n), base);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every cycle out of reset, lanes and pulses must match the schedule exactly.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_beat: expected beat at cycle %0d, now cycle %0d", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        chk("ser_vld", ser_vld, mon_e.vld);
        chk("ser_data", ser_data, mon_e.data);
        chk("frame_done", frame_done, mon_e.done);
      end else begin
        chk("idle_ser_vld", ser_vld, 0);
        chk("idle_ser_data", ser_data, 0);
        chk("idle_frame_done", frame_done, 0);
      end
      while (drop_q.size() > 0 && drop_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_drop: expected drop at cycle %0d, now cycle %0d", drop_q[0], cyc);
        void'(drop_q.pop_front());
      end
      if (drop_q.size() > 0 && drop_q[0] == cyc) begin
        void'(drop_q.pop_front());
        chk("frame_drop", frame_drop, 1);
      end else begin
        chk("idle_frame_drop", frame_drop, 0);
      end
      chk("busy", busy, ser_vld != '0);
      chk("in_ready", in_ready, ser_vld == '0);
    end
  end

  initial begin
    int            b0, b1, guard;
    logic [DW-1:0] d;
    logic [CH-1:0] m;
    logic [CW-1:0] n;

    #1;
    chk("rst_ser_data", ser_data, 0);
    chk("rst_ser_vld", ser_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_drop", frame_drop, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Full 128-bit frame, lane 0, first and last bits set.
    send({32'h8000_0000, 64'h0, 32'h0000_0001}, 8'h01, 16'd128, b0);
    // Three-bit broadcast on lanes 0 and 7.
    send({4'hA, 124'h0}, 8'h81, 16'd3, b0);
    // Zero count and zero mask both drop.
    send({DW{1'b1}}, 8'hFF, 16'd0, b0);
    send({DW{1'b1}}, 8'h00, 16'd16, b0);
    // Over-long count clamps to a full payload.
    send({$urandom, $urandom, $urandom, $urandom}, 8'h10, 16'd200, b0);
    // Back-to-back with in_valid held: one idle cycle between frames.
    send({$urandom, $urandom, $urandom, $urandom}, 8'h5A, 16'd16, b0);
    send({$urandom, $urandom, $urandom, $urandom}, 8'hC3, 16'd32, b1);
    chk("b2b_spacing", b1, b0 + 17);

    // Reset during bit 50 of a full frame loses it silently.
    send({$urandom, $urandom, $urandom, $urandom}, 8'hFF, 16'd128, b0);
    while (cyc < b0 + 49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ser_data", ser_data, 0);
    chk("midrst_ser_vld", ser_vld, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_frame_drop", frame_drop, 0);
    sb.delete();
    drop_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    send({$urandom, $urandom, $urandom, $urandom}, 8'h24, 16'd20, b0);

    // Randomised frames, including drops, clamps and random idle gaps.
    for (int i = 0; i < 30; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : CH'($urandom_range(1, 255));
      case ($urandom_range(0, 9))
        0:       n = 16'd0;
        1:       n = CW'($urandom_range(129, 65535));
        default: n = CW'($urandom_range(1, 128));
      endcase
      send(d, m, n, b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while ((sb.size() > 0 || drop_q.size() > 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb.size() > 0 || drop_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d beats and %0d drops still pending", sb.size(), drop_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
